// File: rtl/alu_serial_seq_pkg.sv
// rtl/alu_serial_seq_pkg.sv - shared types and codes for the bit-serial ALU sequencer
package alu_serial_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_NOR  = 4'b1100;
  localparam logic [3:0] CTL_NAND = 4'b1101;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

endpackage

// File: rtl/alu_top.sv
// rtl/alu_top.sv - 1-bit ALU slice: optional input inversion, AND/OR/full-add/less select
module alu_top
  import alu_serial_seq_pkg::*;
(
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout
);

  logic a;
  logic b;

  always_comb begin
    a    = src1 ^ A_invert;
    b    = src2 ^ B_invert;
    // Carry is produced for every operation so SLT can use the subtract chain.
    cout = (a & b) | (a & cin) | (b & cin);
    case (operation)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a ^ b ^ cin;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - drives one alu_top slice LSB-first over WIDTH cycles, then registers result and flags
// ALU_SERIAL_SLT_OVF_EN: when defined, the SLT set bit is corrected for signed overflow.
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             carry_q,    carry_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic [3:0]       ctl_q,      ctl_d;
  logic [WIDTH-2:0] res_sh_q,   res_sh_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             zero_q,     zero_d;
  logic             cout_q,     cout_d;
  logic             overflow_q, overflow_d;

  logic             slice_cin;
  logic             slice_res;
  logic             slice_cout;
  logic             sum_msb;
  logic             ovf_raw;
  logic             set_bit;
  logic [WIDTH-1:0] final_word;

  alu_top u_slice (
    .src1      (a_q[0]),
    .src2      (b_q[0]),
    .less      (1'b0),
    .A_invert  (ctl_q[3]),
    .B_invert  (ctl_q[2]),
    .cin       (slice_cin),
    .operation (ctl_q[1:0]),
    .result    (slice_res),
    .cout      (slice_cout)
  );

  always_comb begin
    // Bit 0 takes B_invert as carry-in so SUB/SLT get the +1 of two's complement.
    slice_cin = (cnt_q == '0) ? ctl_q[2] : carry_q;
    sum_msb   = (a_q[0] ^ ctl_q[3]) ^ (b_q[0] ^ ctl_q[2]) ^ slice_cin;
    ovf_raw   = slice_cin ^ slice_cout;
`ifdef ALU_SERIAL_SLT_OVF_EN
    set_bit   = sum_msb ^ ovf_raw;
`else
    set_bit   = sum_msb;
`endif
    if (ctl_q == CTL_SLT) begin
      final_word = {{(WIDTH-1){1'b0}}, set_bit};
    end else begin
      final_word = {slice_res, res_sh_q};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    ctl_d      = ctl_q;
    res_sh_d   = res_sh_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = src1;
          b_d     = src2;
          ctl_d   = ALU_control;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_sh_d = {slice_res, res_sh_q[WIDTH-2:1]};
        carry_d  = slice_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d    = ST_FIN;
          result_d   = final_word;
          zero_d     = ~|final_word;
          cout_d     = slice_cout;
          overflow_d = ((ctl_q == CTL_ADD) || (ctl_q == CTL_SUB)) ? ovf_raw : 1'b0;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      ctl_q      <= '0;
      res_sh_q   <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctl_q      <= ctl_d;
      res_sh_q   <= res_sh_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_FIN);
  assign result   = result_q;
  assign zero     = zero_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule
